// File: rtl/accel_defs.sv
// Shared definitions for the FM-index backward-extension engine:
// base codes, controller state codes and Occ word field offsets.
package accel_defs;

    // 2-bit base encodings as stored in the BWT part of an Occ word
    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd1;
    localparam logic [1:0] BASE_G = 2'd2;
    localparam logic [1:0] BASE_T = 2'd3;

    // Controller state codes
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD_K   = 3'd1;
    localparam logic [2:0] ST_WAIT_K = 3'd2;
    localparam logic [2:0] ST_RD_L   = 3'd3;
    localparam logic [2:0] ST_WAIT_L = 3'd4;
    localparam logic [2:0] ST_CALC   = 3'd5;
    localparam logic [2:0] ST_RSP    = 3'd6;

    // LSB of checkpoint count cp[a]; checkpoints sit above the 2*BLK base bits
    function automatic int cp_lsb(input int blk, input int idx_w, input int a);
        return 2 * blk + idx_w * a;
    endfunction

    // LSB of the base stored at in-block position p
    function automatic int base_lsb(input int p);
        return 2 * p;
    endfunction

endpackage

// File: rtl/occ_block_counter.sv
// Combinational Occ evaluator for one checkpointed block: for each base,
// checkpoint count plus the number of matching bases at positions 0..offset.
module occ_block_counter
    import accel_defs::*;
#(
    parameter int IDX_W    = 8,
    parameter int LOG2_BLK = 4
) (
    input  logic [4*IDX_W+2*(1<<LOG2_BLK)-1:0] word_i,
    input  logic [LOG2_BLK-1:0]                offset_i,
    output logic [4*(IDX_W+1)-1:0]             occ_o
);

    localparam int BLK   = 1 << LOG2_BLK;
    localparam int CNT_W = LOG2_BLK + 1;
    localparam int OW    = IDX_W + 1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // Base code handled by this lane
            localparam logic [1:0] LANE_CODE = (gi == 0) ? BASE_A :
                                               (gi == 1) ? BASE_C :
                                               (gi == 2) ? BASE_G : BASE_T;

            logic [CNT_W-1:0] cnt;
            logic [IDX_W-1:0] cp;

            assign cp = word_i[cp_lsb(BLK, IDX_W, gi) +: IDX_W];

            // Masked prefix popcount: matching bases at positions 0..offset inclusive
            always_comb begin
                cnt = '0;
                for (int p = 0; p < BLK; p++) begin
                    if ((LOG2_BLK'(p) <= offset_i) &&
                        (word_i[base_lsb(p) +: 2] == LANE_CODE)) begin
                        cnt = cnt + CNT_W'(1);
                    end
                end
            end

            // One extra bit: checkpoint plus a full block can exceed IDX_W bits
            assign occ_o[gi*OW +: OW] = {1'b0, cp} + OW'(cnt);
        end
    endgenerate

endmodule

// File: rtl/occ_extend_engine.sv
// FM-index backward-extension engine. One request (k,l) yields the extended
// intervals for all four bases: k'[a]=C[a]+Occ(a,k-1)+1, l'[a]=C[a]+Occ(a,l).
// Occ blocks come from a fixed-latency ROM; when k-1 and l fall in the same
// block a single read serves both ends.
module occ_extend_engine
    import accel_defs::*;
#(
    parameter int IDX_W    = 8,
    parameter int LOG2_BLK = 4,
    parameter int TAG_W    = 12,
    parameter int MEM_LAT  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [IDX_W-1:0]                    req_k_i,
    input  logic [IDX_W-1:0]                    req_l_i,
    input  logic [TAG_W-1:0]                    req_tag_i,
    input  logic [4*IDX_W-1:0]                  c_table_i,
    output logic                                mem_ce_o,
    output logic [IDX_W-LOG2_BLK-1:0]           mem_addr_o,
    input  logic [4*IDX_W+2*(1<<LOG2_BLK)-1:0]  mem_data_i,
    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic [TAG_W-1:0]                    rsp_tag_o,
    output logic [4*IDX_W-1:0]                  rsp_k_o,
    output logic [4*IDX_W-1:0]                  rsp_l_o,
    output logic [3:0]                          rsp_empty_o,
    output logic [3:0]                          rsp_ovf_o,
    output logic                                busy_o
);

    localparam int AW = IDX_W - LOG2_BLK;
    localparam int OW = IDX_W + 1;
    localparam int SW = IDX_W + 2;
    localparam logic [SW-1:0] MAX_VAL = SW'((1 << IDX_W) - 1);

    // Controller state
    logic [2:0]         state_q, state_d;
    logic [IDX_W-1:0]   k_q, l_q;
    logic [TAG_W-1:0]   tag_q;
    logic [1:0]         wait_cnt_q;
    logic [AW-1:0]      addr_q;

    // Captured Occ counts per lane
    logic [4*OW-1:0]    occ_k_q, occ_l_q;
    logic [4*OW-1:0]    occ_k_w, occ_l_w;

    // Registered results
    logic [4*IDX_W-1:0] rsp_k_q, rsp_k_d;
    logic [4*IDX_W-1:0] rsp_l_q, rsp_l_d;
    logic [3:0]         empty_q, empty_d;
    logic [3:0]         ovf_q, ovf_d;

    // Helpers
    logic [IDX_W-1:0]   km1;
    logic [AW-1:0]      blk_km1, blk_l, req_blk_km1;
    logic               same_blk, last_wait, req_fire, in_wait;

    assign km1         = k_q - IDX_W'(1);
    assign blk_km1     = km1[IDX_W-1:LOG2_BLK];
    assign blk_l       = l_q[IDX_W-1:LOG2_BLK];
    assign req_blk_km1 = AW'((req_k_i - IDX_W'(1)) >> LOG2_BLK);
    assign same_blk    = (blk_km1 == blk_l);
    assign last_wait   = (wait_cnt_q == 2'(MEM_LAT - 1));
    assign in_wait     = (state_q == ST_WAIT_K) || (state_q == ST_WAIT_L);
    assign req_fire    = req_valid_i && (state_q == ST_IDLE);

    // Both ends of the interval are evaluated against whatever word the ROM returns;
    // the controller decides which result is kept.
    occ_block_counter #(
        .IDX_W    (IDX_W),
        .LOG2_BLK (LOG2_BLK)
    ) u_cnt_k (
        .word_i   (mem_data_i),
        .offset_i (km1[LOG2_BLK-1:0]),
        .occ_o    (occ_k_w)
    );

    occ_block_counter #(
        .IDX_W    (IDX_W),
        .LOG2_BLK (LOG2_BLK)
    ) u_cnt_l (
        .word_i   (mem_data_i),
        .offset_i (l_q[LOG2_BLK-1:0]),
        .occ_o    (occ_l_w)
    );

    // Next-state logic: k==0 skips the k-1 read, a same-block hit skips the l read
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_fire) state_d = (req_k_i == '0) ? ST_RD_L : ST_RD_K;
            ST_RD_K:   state_d = ST_WAIT_K;
            ST_WAIT_K: if (last_wait) state_d = same_blk ? ST_CALC : ST_RD_L;
            ST_RD_L:   state_d = ST_WAIT_L;
            ST_WAIT_L: if (last_wait) state_d = ST_CALC;
            ST_CALC:   state_d = ST_RSP;
            ST_RSP:    if (rsp_ready_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Control registers: state, latched request, ROM address, wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            l_q        <= '0;
            tag_q      <= '0;
            addr_q     <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                k_q    <= req_k_i;
                l_q    <= req_l_i;
                tag_q  <= req_tag_i;
                addr_q <= (req_k_i == '0) ? req_l_i[IDX_W-1:LOG2_BLK] : req_blk_km1;
            end else if ((state_q == ST_WAIT_K) && last_wait && !same_blk) begin
                addr_q <= blk_l;
            end
            if (in_wait && !last_wait) begin
                wait_cnt_q <= wait_cnt_q + 2'd1;
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

    // Occ capture: only on the last wait cycle, when the ROM word is valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_k_q <= '0;
            occ_l_q <= '0;
        end else begin
            if (req_fire) begin
                occ_k_q <= '0;              // Occ(a,-1) = 0 when k == 0
            end
            if ((state_q == ST_WAIT_K) && last_wait) begin
                occ_k_q <= occ_k_w;
                if (same_blk) begin
                    occ_l_q <= occ_l_w;
                end
            end
            if ((state_q == ST_WAIT_L) && last_wait) begin
                occ_l_q <= occ_l_w;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_calc
            logic [SW-1:0] c_ext, sum_k, sum_l;

            assign c_ext = SW'(c_table_i[gi*IDX_W +: IDX_W]);
            assign sum_k = c_ext + SW'(occ_k_q[gi*OW +: OW]) + SW'(1);
            assign sum_l = c_ext + SW'(occ_l_q[gi*OW +: OW]);

            // Emptiness uses the unsaturated sums so saturation cannot hide it
            assign empty_d[gi] = (sum_k > sum_l);
            assign ovf_d[gi]   = (sum_k > MAX_VAL) || (sum_l > MAX_VAL);
            assign rsp_k_d[gi*IDX_W +: IDX_W] = (sum_k > MAX_VAL) ? {IDX_W{1'b1}} : sum_k[IDX_W-1:0];
            assign rsp_l_d[gi*IDX_W +: IDX_W] = (sum_l > MAX_VAL) ? {IDX_W{1'b1}} : sum_l[IDX_W-1:0];
        end
    endgenerate

    // Result registers: loaded once in CALC and held through the response phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_k_q <= '0;
            rsp_l_q <= '0;
            empty_q <= '0;
            ovf_q   <= '0;
        end else if (state_q == ST_CALC) begin
            rsp_k_q <= rsp_k_d;
            rsp_l_q <= rsp_l_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
        end
    end

    // Ready is masked by reset so every output reads zero while reset is held
    assign req_ready_o = (state_q == ST_IDLE) && !rst;
    assign busy_o      = (state_q != ST_IDLE);
    assign mem_ce_o    = (state_q == ST_RD_K) || (state_q == ST_RD_L);
    assign mem_addr_o  = addr_q;
    assign rsp_valid_o = (state_q == ST_RSP);
    assign rsp_tag_o   = tag_q;
    assign rsp_k_o     = rsp_k_q;
    assign rsp_l_o     = rsp_l_q;
    assign rsp_empty_o = empty_q;
    assign rsp_ovf_o   = ovf_q;

endmodule

// File: tb/tb_occ_extend_engine.sv
// Bench for occ_extend_engine: behavioural BWT/Occ model, ROM model,
// per-cycle scoreboard compare, directed literal checks and random traffic.
module tb_occ_extend_engine;

    localparam int IDX_W    = 8;
    localparam int LOG2_BLK = 4;
    localparam int TAG_W    = 12;
    localparam int MEM_LAT  = 1;
    localparam int BLK      = 16;
    localparam int NBLK     = 16;
    localparam int WW       = 4*IDX_W + 2*BLK;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   req_valid_i = 1'b0;
    logic                   req_ready_o;
    logic [IDX_W-1:0]       req_k_i = '0;
    logic [IDX_W-1:0]       req_l_i = '0;
    logic [TAG_W-1:0]       req_tag_i = '0;
    logic [4*IDX_W-1:0]     c_table_i = '0;
    logic                   mem_ce_o;
    logic [IDX_W-LOG2_BLK-1:0] mem_addr_o;
    logic [WW-1:0]          mem_data_i;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i = 1'b0;
    logic [TAG_W-1:0]       rsp_tag_o;
    logic [4*IDX_W-1:0]     rsp_k_o;
    logic [4*IDX_W-1:0]     rsp_l_o;
    logic [3:0]             rsp_empty_o;
    logic [3:0]             rsp_ovf_o;
    logic                   busy_o;

    occ_extend_engine #(
        .IDX_W    (IDX_W),
        .LOG2_BLK (LOG2_BLK),
        .TAG_W    (TAG_W),
        .MEM_LAT  (MEM_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_k_i     (req_k_i),
        .req_l_i     (req_l_i),
        .req_tag_i   (req_tag_i),
        .c_table_i   (c_table_i),
        .mem_ce_o    (mem_ce_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_tag_o   (rsp_tag_o),
        .rsp_k_o     (rsp_k_o),
        .rsp_l_o     (rsp_l_o),
        .rsp_empty_o (rsp_empty_o),
        .rsp_ovf_o   (rsp_ovf_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference data ----------------
    int            bwt [256];
    logic [WW-1:0] rom [NBLK];
    logic [WW-1:0] rd_q;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM with one cycle latency; garbage when not enabled
    always @(posedge clk) rd_q <= mem_ce_o ? rom[mem_addr_o] : {$urandom, $urandom};
    assign mem_data_i = rd_q;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      k;
        logic [31:0]      l;
        logic [3:0]       emp;
        logic [3:0]       ovf;
        int               acc;
        int               lat;
    } exp_t;

    exp_t exp_q[$];
    int   addr_exp[$];
    int   tests = 0;
    int   fails = 0;
    bit   outstanding = 0;
    bit   head_seen = 0;
    bit   bp_hold = 0;
    int   rsp_count = 0;
    int   n_sent = 0;
    int   rd_count = 0;
    int   last_lat = 0;
    logic [31:0]      last_k = '0;
    logic [31:0]      last_l = '0;
    logic [3:0]       last_emp = '0;
    logic [3:0]       last_ovf = '0;
    logic [TAG_W-1:0] last_tag = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Occ(a,i) straight from the BWT
    function automatic int occ(input int a, input int i);
        int n = 0;
        for (int p = 0; p <= i; p++) if (bwt[p] == a) n++;
        return n;
    endfunction

    function automatic exp_t model(input int k, input int l, input int tag, input logic [31:0] c);
        exp_t e;
        int   kk, ll;
        e.tag = TAG_W'(tag);
        e.k = '0; e.l = '0; e.emp = '0; e.ovf = '0; e.acc = 0;
        for (int a = 0; a < 4; a++) begin
            kk = int'(c[a*8 +: 8]) + occ(a, k - 1) + 1;
            ll = int'(c[a*8 +: 8]) + occ(a, l);
            e.emp[a] = (kk > ll);
            e.ovf[a] = (kk > 255) || (ll > 255);
            e.k[a*8 +: 8] = 8'((kk > 255) ? 255 : kk);
            e.l[a*8 +: 8] = 8'((ll > 255) ? 255 : ll);
        end
        e.lat = (k == 0 || ((k - 1) / BLK) == (l / BLK)) ? 3 + MEM_LAT : 4 + 2*MEM_LAT;
        return e;
    endfunction

    // Per-cycle compare process (samples on the falling edge)
    initial begin
        exp_t e;
        bit   was_idle;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_outputs", {rsp_valid_o, req_ready_o, mem_ce_o, busy_o, |rsp_k_o, |rsp_l_o,
                                      |rsp_empty_o, |rsp_ovf_o, |rsp_tag_o, |mem_addr_o}, 64'd0);
                exp_q.delete();
                addr_exp.delete();
                outstanding = 0;
                head_seen = 0;
            end else begin
                was_idle = !outstanding;
                check("req_ready", req_ready_o, was_idle);
                check("busy", busy_o, !was_idle);
                if (mem_ce_o) begin
                    rd_count++;
                    check("read_expected", addr_exp.size() > 0, 1);
                    if (addr_exp.size() > 0) begin
                        check("mem_addr", mem_addr_o, addr_exp[0]);
                        void'(addr_exp.pop_front());
                    end
                end
                if (rsp_valid_o) begin
                    check("rsp_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q[0];
                        if (!head_seen) begin
                            last_lat = cyc - e.acc;
                            check("latency", last_lat, e.lat);
                            head_seen = 1;
                        end
                        check("rsp_tag", rsp_tag_o, e.tag);
                        check("rsp_k", rsp_k_o, e.k);
                        check("rsp_l", rsp_l_o, e.l);
                        check("rsp_empty", rsp_empty_o, e.emp);
                        check("rsp_ovf", rsp_ovf_o, e.ovf);
                        if (rsp_ready_i) begin
                            last_k = rsp_k_o; last_l = rsp_l_o; last_emp = rsp_empty_o;
                            last_ovf = rsp_ovf_o; last_tag = rsp_tag_o;
                            void'(exp_q.pop_front());
                            head_seen = 0;
                            outstanding = 0;
                            rsp_count++;
                        end
                    end
                end
                if (req_valid_i && was_idle) begin
                    e = model(int'(req_k_i), int'(req_l_i), int'(req_tag_i), c_table_i);
                    e.acc = cyc;
                    exp_q.push_back(e);
                    outstanding = 1;
                    if (req_k_i == 0) begin
                        addr_exp.push_back(int'(req_l_i) / BLK);
                    end else begin
                        addr_exp.push_back((int'(req_k_i) - 1) / BLK);
                        if (((int'(req_k_i) - 1) / BLK) != (int'(req_l_i) / BLK))
                            addr_exp.push_back(int'(req_l_i) / BLK);
                    end
                end
            end
        end
    end

    // Response ready: random unless held low
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready_i = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input int k, input int l, input int tag);
        bit taken = 0;
        req_k_i = IDX_W'(k);
        req_l_i = IDX_W'(l);
        req_tag_i = TAG_W'(tag);
        req_valid_i = 1'b1;
        for (int n = 0; n < 300 && !taken; n++) begin
            @(negedge clk);
            taken = req_ready_o && !rst;
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
        check("req_accepted", taken, 1);
        n_sent++;
        $display("[TB] req k=%0d l=%0d tag=%0h accepted=%0d", k, l, tag, taken);
    endtask

    task automatic wait_all();
        for (int n = 0; n < 400 && rsp_count < n_sent; n++) @(posedge clk);
        check("rsp_count", rsp_count, n_sent);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        int r0, k, l;
        // BWT: block0 all C, block1 all G, block2 all A, block3 10xT then A,
        // block4 all T, remainder random
        for (int p = 0; p < 256; p++) begin
            if (p < 16)       bwt[p] = 1;
            else if (p < 32)  bwt[p] = 2;
            else if (p < 48)  bwt[p] = 0;
            else if (p < 58)  bwt[p] = 3;
            else if (p < 64)  bwt[p] = 0;
            else if (p < 80)  bwt[p] = 3;
            else              bwt[p] = int'($urandom_range(0, 3));
        end
        for (int b = 0; b < NBLK; b++) begin
            logic [WW-1:0] w;
            w = '0;
            for (int a = 0; a < 4; a++) w[2*BLK + 8*a +: 8] = 8'(occ(a, b*BLK - 1));
            for (int p = 0; p < BLK; p++) w[2*p +: 2] = 2'(bwt[b*BLK + p]);
            rom[b] = w;
        end
        c_table_i = {8'd40, 8'd30, 8'd10, 8'd0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Same block
        r0 = rd_count;
        send(1, 5, 12'h101);
        wait_all();
        check("t1_reads", rd_count - r0, 1);
        check("t1_latency", last_lat, 4);
        check("t1_C_k", last_k[15:8], 12);
        check("t1_C_l", last_l[15:8], 16);
        check("t1_C_empty", last_emp[1], 0);
        check("t1_A_k", last_k[7:0], 1);
        check("t1_A_l", last_l[7:0], 0);
        check("t1_A_empty", last_emp[0], 1);

        // k == 0
        r0 = rd_count;
        send(0, 3, 12'h102);
        wait_all();
        check("t2_reads", rd_count - r0, 1);
        check("t2_C_k", last_k[15:8], 11);
        check("t2_C_l", last_l[15:8], 14);
        check("t2_empty", last_emp, 4'b1101);

        // Two blocks
        r0 = rd_count;
        send(20, 40, 12'h103);
        wait_all();
        check("t3_reads", rd_count - r0, 2);
        check("t3_latency", last_lat, 6);
        check("t3_G_k", last_k[23:16], 35);
        check("t3_G_l", last_l[23:16], 46);
        check("t3_C_k", last_k[15:8], 27);
        check("t3_C_l", last_l[15:8], 26);
        check("t3_C_empty", last_emp[1], 1);

        // Overflow on lane T
        c_table_i = {8'd250, 8'd30, 8'd10, 8'd0};
        send(64, 64, 12'h104);
        wait_all();
        check("t4_T_l", last_l[31:24], 255);
        check("t4_T_ovf", last_ovf[3], 1);
        check("t4_T_empty", last_emp[3], 0);
        c_table_i = {8'd40, 8'd30, 8'd10, 8'd0};

        // Backpressure with a second request waiting
        bp_hold = 1;
        send(1, 5, 12'h201);
        fork
            send(20, 40, 12'h202);
            begin
                repeat (10) @(posedge clk);
                bp_hold = 0;
            end
        join
        wait_all();
        check("bp_last_tag", last_tag, 12'h202);

        // Reset during WAIT_L
        send(20, 40, 12'h301);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", busy_o, 1);
        rst = 1'b1;
        #1;
        check("rst_async", {busy_o, mem_ce_o, rsp_valid_o, req_ready_o}, 4'b0000);
        n_sent--;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(1, 5, 12'h302);
        wait_all();
        check("post_rst_tag", last_tag, 12'h302);
        check("post_rst_C_k", last_k[15:8], 12);

        // Random traffic
        for (int i = 0; i < 120; i++) begin
            if (i % 10 == 0) begin
                wait_all();
                c_table_i = $urandom;
            end
            k = int'($urandom_range(0, 255));
            l = (i % 3 == 0) ? ((k + int'($urandom_range(0, 15))) & 255) : int'($urandom_range(0, 255));
            send(k, l, int'($urandom_range(0, 4095)));
        end
        wait_all();

        check("addr_queue_drained", addr_exp.size(), 0);
        check("rsp_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
